uart_fifo_ip: RTL

UART_FIFO_IP -- requirements
Module: uart_fifo_ip

---
 rtl/uart_fifo_ip.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo_ip.sv
// uart_fifo_ip: UART transmitter and receiver, each buffered by a show-ahead FIFO,
// with independent per-frame baud selection, optional parity and one or two stop bits.
module uart_fifo_ip #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int BASE_DIV   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 uart_en,
    input  logic [2:0]           baud_tx_sel,
    input  logic [2:0]           baud_rx_sel,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 TX,
    input  logic                 RX
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(BASE_DIV) + 8;
    localparam logic [3:0] LAST = 4'(DATA_BITS - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [AW:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic tx_empty, tx_full, tx_push, tx_pop, tx_load, rx_empty, rx_full, rx_pop, rx_wr, en_q;
    logic [DATA_BITS-1:0] tx_head;
    assign tx_empty = tx_wp == tx_rp;
    assign tx_full  = tx_wp == {~tx_rp[AW], tx_rp[AW-1:0]};
    assign rx_empty = rx_wp == rx_rp;
    assign rx_full  = rx_wp == {~rx_rp[AW], rx_rp[AW-1:0]};
    // en_q keeps tx_ready low until the first edge after reset is released
    assign tx_ready = en_q & uart_en & ~tx_full;
    assign tx_push  = tx_valid & tx_ready;
    assign tx_head  = tx_mem[tx_rp[AW-1:0]];
    assign rx_valid = ~rx_empty;
    assign rx_pop   = rx_valid & rx_ready;
    assign rx_data  = rx_empty ? '0 : rx_mem[rx_rp[AW-1:0]];

    state_t tx_st, tx_st_n, rx_st, rx_st_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n, tx_per, tx_per_n, rx_cnt, rx_cnt_n, rx_per, rx_per_n;
    logic [3:0] tx_idx, tx_idx_n, rx_idx, rx_idx_n;
    logic [DATA_BITS-1:0] tx_sh, tx_sh_n, rx_sh, rx_sh_n;
    logic tx_par, tx_par_n, tx_pen, tx_pen_n, tx_two, tx_two_n, tx_end;
    logic rx_pen, rx_pen_n, rx_odd, rx_odd_n, rx_pbit, rx_pbit_n, rx_tick;
    logic pe_n, fe_n, ov_n;
    logic [1:0] rx_sync;
    logic rx_prev, rx_s, rx_fall;
    assign rx_s    = rx_sync[1];
    assign rx_fall = rx_prev & ~rx_s;
    assign tx_end  = tx_cnt == tx_per - 1'b1;
    assign rx_tick = rx_cnt == (rx_st == START ? rx_per >> 1 : rx_per) - 1'b1;
    assign tx_busy = (tx_st != IDLE) | ~tx_empty;
    assign TX = ~uart_en | (tx_st == START ? 1'b0 : tx_st == DATA ? tx_sh[0] : tx_st == PARITY ? tx_par : 1'b1);

    always_ff @(posedge clock) begin
        if (tx_push) tx_mem[tx_wp[AW-1:0]] <= tx_data;
        if (rx_wr) rx_mem[rx_wp[AW-1:0]] <= rx_sh;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            en_q <= 1'b0;
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
            tx_st <= IDLE;
            tx_cnt <= '0;
            tx_per <= '0;
            tx_idx <= '0;
            tx_sh <= '0;
            tx_par <= 1'b0;
            tx_pen <= 1'b0;
            tx_two <= 1'b0;
            rx_st <= IDLE;
            rx_cnt <= '0;
            rx_per <= '0;
            rx_idx <= '0;
            rx_sh <= '0;
            rx_pen <= 1'b0;
            rx_odd <= 1'b0;
            rx_pbit <= 1'b0;
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
            parity_err <= 1'b0;
            frame_err <= 1'b0;
            overrun <= 1'b0;
        end else begin
            en_q <= 1'b1;
            tx_wp <= tx_wp + {{AW{1'b0}}, tx_push};
            tx_rp <= tx_rp + {{AW{1'b0}}, tx_pop};
            rx_wp <= rx_wp + {{AW{1'b0}}, rx_wr};
            rx_rp <= rx_rp + {{AW{1'b0}}, rx_pop};
            tx_st <= tx_st_n;
            tx_cnt <= tx_cnt_n;
            tx_per <= tx_per_n;
            tx_idx <= tx_idx_n;
            tx_sh <= tx_sh_n;
            tx_par <= tx_par_n;
            tx_pen <= tx_pen_n;
            tx_two <= tx_two_n;
            rx_st <= rx_st_n;
            rx_cnt <= rx_cnt_n;
            rx_per <= rx_per_n;
            rx_idx <= rx_idx_n;
            rx_sh <= rx_sh_n;
            rx_pen <= rx_pen_n;
            rx_odd <= rx_odd_n;
            rx_pbit <= rx_pbit_n;
            rx_sync <= {rx_sync[0], RX};
            rx_prev <= rx_s;
            parity_err <= pe_n;
            frame_err <= fe_n;
            overrun <= ov_n;
        end
    end

    always_comb begin
        tx_st_n  = tx_st;
        tx_cnt_n = (tx_st == IDLE || tx_end) ? '0 : tx_cnt + 1'b1;
        tx_per_n = tx_per;
        tx_idx_n = tx_idx;
        tx_sh_n  = tx_sh;
        tx_par_n = tx_par;
        tx_pen_n = tx_pen;
        tx_two_n = tx_two;
        tx_load  = 1'b0;
        case (tx_st)
            IDLE:   tx_load = ~tx_empty;
            START:  if (tx_end) tx_st_n = DATA;
            DATA:   if (tx_end) begin
                        tx_sh_n  = tx_sh >> 1;
                        tx_idx_n = tx_idx + 1'b1;
                        if (tx_idx == LAST) begin
                            tx_st_n  = tx_pen ? PARITY : STOP;
                            tx_idx_n = '0;
                        end
                    end
            PARITY: if (tx_end) tx_st_n = STOP;
            STOP:   if (tx_end) begin
                        tx_idx_n = 4'd1;
                        // last stop period: chain straight into the next frame if one is queued
                        if (!(tx_two && tx_idx == 4'd0)) begin
                            tx_st_n = IDLE;
                            tx_load = ~tx_empty;
                        end
                    end
            default: tx_st_n = IDLE;
        endcase
        if (tx_load) begin
            tx_st_n  = START;
            tx_cnt_n = '0;
            tx_idx_n = '0;
            tx_per_n = CW'(BASE_DIV) << (3'd7 - baud_tx_sel);
            tx_sh_n  = tx_head;
            tx_par_n = ^tx_head ^ (parity_mode == 2'b10);
            tx_pen_n = ^parity_mode;
            tx_two_n = two_stop;
        end
        if (!uart_en) begin
            tx_st_n = IDLE;
            tx_load = 1'b0;
        end
        tx_pop = tx_load;
    end

    always_comb begin
        rx_st_n   = rx_st;
        rx_cnt_n  = (rx_st == IDLE || rx_tick) ? '0 : rx_cnt + 1'b1;
        rx_per_n  = rx_per;
        rx_idx_n  = rx_idx;
        rx_sh_n   = rx_sh;
        rx_pen_n  = rx_pen;
        rx_odd_n  = rx_odd;
        rx_pbit_n = rx_pbit;
        pe_n  = 1'b0;
        fe_n  = 1'b0;
        ov_n  = 1'b0;
        rx_wr = 1'b0;
        case (rx_st)
            IDLE:   if (rx_fall) begin
                        rx_st_n  = START;
                        rx_per_n = CW'(BASE_DIV) << (3'd7 - baud_rx_sel);
                        rx_pen_n = ^parity_mode;
                        rx_odd_n = parity_mode == 2'b10;
                    end
            START:  if (rx_tick) begin
                        rx_st_n  = rx_s ? IDLE : DATA;
                        rx_idx_n = '0;
                    end
            DATA:   if (rx_tick) begin
                        rx_sh_n  = {rx_s, rx_sh[DATA_BITS-1:1]};
                        rx_idx_n = rx_idx + 1'b1;
                        if (rx_idx == LAST) rx_st_n = rx_pen ? PARITY : STOP;
                    end
            PARITY: if (rx_tick) begin
                        rx_pbit_n = rx_s;
                        rx_st_n   = STOP;
                    end
            STOP:   if (rx_tick) begin
                        rx_st_n = IDLE;
                        fe_n  = ~rx_s;
                        pe_n  = rx_pen & (rx_pbit != (^rx_sh ^ rx_odd));
                        rx_wr = rx_s & ~pe_n & ~(rx_full & ~rx_pop);
                        ov_n  = rx_s & ~pe_n & rx_full & ~rx_pop;
                    end
            default: rx_st_n = IDLE;
        endcase
        if (!uart_en) begin
            rx_st_n = IDLE;
            pe_n  = 1'b0;
            fe_n  = 1'b0;
            ov_n  = 1'b0;
            rx_wr = 1'b0;
        end
    end
endmodule
